// File: rtl/sseg_scan_if.sv
// ---------------------------------------------------------------------------
// sseg_scan_if -- signal bundle between the display scan controller and the
// logic around it (control inputs plus the digit-select / anode outputs).
//
//   scan_en     controller input   1 = scan runs, 0 = freeze and blank
//   en_mask     controller input   bit i = 1 lets digit i light in its slot
//   sel         controller output  current digit index for the segment mux
//   an          controller output  active-low anode enables (one low or none)
//   slot_start  controller output  one-cycle pulse on the first cycle of a slot
//
// master : the side that drives scan_en/en_mask and consumes the outputs
// slave  : the scan controller itself
// ---------------------------------------------------------------------------
interface sseg_scan_if;
  logic       scan_en;
  logic [7:0] en_mask;
  logic [2:0] sel;
  logic [7:0] an;
  logic       slot_start;

  modport master (
    output scan_en,
    output en_mask,
    input  sel,
    input  an,
    input  slot_start
  );

  modport slave (
    input  scan_en,
    input  en_mask,
    output sel,
    output an,
    output slot_start
  );
endinterface : sseg_scan_if

// File: rtl/sseg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// sseg_scan_ctrl -- time base and digit selector for an 8-digit multiplexed
// seven-segment display.
//
// Each digit owns a slot of SLOT_CYCLES clocks. The first BLANK_CYCLES of
// every slot keep all anodes off so the segment pattern can settle on the new
// digit without ghosting onto the previous one. Disabled digits still take
// their slot, so the frame period is always 8 * SLOT_CYCLES.
//
// Ports
//   clk     system clock, rising edge
//   reset   synchronous, active-high; overrides everything
//   bus     sseg_scan_if.slave : scan_en, en_mask in; sel, an, slot_start out
//
// Parameters
//   SLOT_CYCLES   clocks per digit slot (>= 2)
//   BLANK_CYCLES  dead clocks at the start of each slot (0 .. SLOT_CYCLES-1)
// ---------------------------------------------------------------------------
module sseg_scan_ctrl #(
  parameter int SLOT_CYCLES  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset,
  sseg_scan_if.slave  bus
);

  localparam int CNT_W = $clog2(SLOT_CYCLES);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);

  localparam logic [7:0] AN_OFF = 8'hFF;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       sel_q, sel_d;
  logic [7:0]       an_q,  an_d;
  logic             slot_start_q, slot_start_d;
  logic             digit_on;

  // Next-state logic. The anode pattern is derived from the *next* cnt/sel
  // so that, once registered, it always lines up with the sel and cnt that
  // are visible in the same cycle -- the blank window can never straddle a
  // sel change, and at most one anode is ever low.
  // NOTE: every signal driven here gets a default first, so no path leaves a
  // value unassigned and no latch can be inferred.
  always_comb begin
    cnt_d        = cnt_q;
    sel_d        = sel_q;
    slot_start_d = 1'b0;

    if (bus.scan_en) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d        = '0;
        sel_d        = sel_q + 3'd1;  // wraps 7 -> 0 naturally
        slot_start_d = 1'b1;          // only a real wrap raises the pulse
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // Frozen scan blanks the display; a masked digit stays dark for its slot.
    digit_on = bus.scan_en && bus.en_mask[sel_d] && (cnt_d >= CNT_BLANK);
    an_d     = digit_on ? ~(8'b1 << sel_d) : AN_OFF;
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q        <= '0;
      sel_q        <= '0;
      an_q         <= AN_OFF;
      slot_start_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      an_q         <= an_d;
      slot_start_q <= slot_start_d;
    end
  end

  assign bus.sel        = sel_q;
  assign bus.an         = an_q;
  assign bus.slot_start = slot_start_q;

endmodule : sseg_scan_ctrl
